skew_loader: RTL and testbench

- Downstream consumer of decoded LD instructions (opcode, buf_id, mem_loc) from the instruction reader.
- Fetches a DIM x DIM tile row-by-row from the operand scratch memory and holds it in a local tile register.
- Writes the tile into the left or top systolic SRAM bank as 2*DIM-1 diagonally skewed beats.
- Then publishes that bank's read start/end addresses to the array controller.

---
 rtl/skew_loader_pkg.sv | 28 ++
 rtl/skew_diag_mux.sv | 33 +++
 rtl/skew_loader.sv | 226 ++++++++++++++++++++++
 tb/tb_skew_loader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/skew_loader_pkg.sv
// Shared definitions for the skew loader slice.
//   - Default array geometry (DIM, DATA_WIDTH).
//   - Buffer-select codes carried in the LD instruction's buf_id field.
//   - Opcode values of the instruction stream the loader sits behind.
//   - Loader FSM state encoding.
package skew_loader_pkg;

  localparam int DIM_DEFAULT        = 8;
  localparam int DATA_WIDTH_DEFAULT = 8;

  // buf_id values; anything else is an illegal target.
  localparam logic [1:0] BUF_LEFT = 2'b00;
  localparam logic [1:0] BUF_TOP  = 2'b01;

  // Instruction opcodes decoded upstream.
  localparam logic [3:0] OP_LD       = 4'b0010;
  localparam logic [3:0] OP_ST       = 4'b0011;
  localparam logic [3:0] OP_GEMM     = 4'b0100;
  localparam logic [3:0] OP_DRAINSYS = 4'b0101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EMIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/skew_diag_mux.sv
// Combinational diagonal-skew selector.
// For beat k, lane j carries tile[k-j][j] when 0 <= k-j <= DIM-1, else 0.
// Ports:
//   tile  in   DIM rows of DIM*DATA_WIDTH bits (row r = tile[r])
//   beat  in   beat index k, 0 .. 2*DIM-2
//   row   out  skewed beat, lane j at bits j*DATA_WIDTH +: DATA_WIDTH
module skew_diag_mux
  import skew_loader_pkg::*;
#(
  parameter int DIM        = DIM_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int BEAT_W     = $clog2(2 * DIM)
) (
  input  logic [DIM-1:0][DIM*DATA_WIDTH-1:0] tile,
  input  logic [BEAT_W-1:0]                  beat,
  output logic [DIM*DATA_WIDTH-1:0]          row
);

  localparam int ROW_IDX_W = $clog2(DIM);

  for (genvar j = 0; j < DIM; j++) begin : g_lane
    // diff = beat - j computed one bit wider; the top bit is the borrow,
    // so a set borrow means the diagonal has not reached this lane yet.
    logic [BEAT_W:0] diff;
    logic            hit;

    assign diff = {1'b0, beat} - (BEAT_W + 1)'(j);
    assign hit  = !diff[BEAT_W] && (diff < (BEAT_W + 1)'(DIM));
    assign row[j*DATA_WIDTH +: DATA_WIDTH] =
      hit ? tile[diff[ROW_IDX_W-1:0]][j*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

endmodule

// File: rtl/skew_loader.sv
// LD-instruction consumer: fetches a DIM x DIM tile from the operand
// scratch memory row by row, then writes it into the left or top systolic
// SRAM bank as 2*DIM-1 diagonally skewed beats, and finally publishes that
// bank's read start/end addresses for the array controller.
//
// Command handshake: a command transfers on a rising edge where cmd_valid
// and cmd_ready are both high. cmd_ready is high only in IDLE while reset is
// released; the fields (cmd_buf_id, cmd_mem_loc) are sampled at that edge.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready              LD command handshake
//   cmd_buf_id                       0 = left bank, 1 = top bank, else illegal
//   cmd_mem_loc                      base address for both fetch and write
//   src_rd_en/src_rd_addr            scratch read request
//   src_rd_data                      scratch row, valid 1 cycle after request
//   i_left_wr_en/addr/data           left bank write port
//   i_top_wr_en/addr/data            top bank write port
//   i_left_sram_rd_start/end_addr    published left read window (inclusive)
//   i_top_sram_rd_start/end_addr     published top read window (inclusive)
//   done                             one-cycle completion pulse
//   err                              one-cycle pulse for an illegal buf_id
//
// Timing from acceptance at T0: reads issue T1..T_DIM, captures land
// T2..T_DIM+1, beats go out T_DIM+2..T_3DIM, done at T_3DIM+1.
module skew_loader
  import skew_loader_pkg::*;
#(
  parameter int DIM                  = DIM_DEFAULT,
  parameter int DATA_WIDTH           = DATA_WIDTH_DEFAULT,
  parameter int BUF_ID_WIDTH         = 2,
  parameter int MEM_LOC_WIDTH        = 10,
  parameter int LOG2_SRAM_BANK_DEPTH = 10,
  parameter int LOG2_SRC_DEPTH       = 10
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [BUF_ID_WIDTH-1:0]         cmd_buf_id,
  input  logic [MEM_LOC_WIDTH-1:0]        cmd_mem_loc,
  output logic                            src_rd_en,
  output logic [LOG2_SRC_DEPTH-1:0]       src_rd_addr,
  input  logic [DIM*DATA_WIDTH-1:0]       src_rd_data,
  output logic                            i_left_wr_en,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] i_left_wr_addr,
  output logic [DIM*DATA_WIDTH-1:0]       i_left_wr_data,
  output logic                            i_top_wr_en,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] i_top_wr_addr,
  output logic [DIM*DATA_WIDTH-1:0]       i_top_wr_data,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] i_left_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] i_left_sram_rd_end_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] i_top_sram_rd_start_addr,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0] i_top_sram_rd_end_addr,
  output logic                            done,
  output logic                            err
);

  localparam int ROW_BITS  = DIM * DATA_WIDTH;
  localparam int CNT_W     = $clog2(2 * DIM);
  localparam int ROW_IDX_W = $clog2(DIM);
  localparam int EXT_W0    = (MEM_LOC_WIDTH > LOG2_SRC_DEPTH) ? MEM_LOC_WIDTH : LOG2_SRC_DEPTH;
  localparam int EXT_W     = (EXT_W0 > LOG2_SRAM_BANK_DEPTH) ? EXT_W0 : LOG2_SRAM_BANK_DEPTH;

  state_t                            state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q;
  logic [BUF_ID_WIDTH-1:0]           buf_q;
  logic [LOG2_SRC_DEPTH-1:0]         src_base_q;
  logic [LOG2_SRAM_BANK_DEPTH-1:0]   sram_base_q;
  logic [DIM-1:0][ROW_BITS-1:0]      tile_q;
  logic                              err_q;
  logic [LOG2_SRAM_BANK_DEPTH-1:0]   left_start_q, left_end_q;
  logic [LOG2_SRAM_BANK_DEPTH-1:0]   top_start_q, top_end_q;

  logic                              accept;
  logic                              cmd_legal;
  logic [EXT_W-1:0]                  loc_ext;
  logic                              fetch_last;
  logic                              emit_last;
  logic                              sel_left;
  logic                              sel_top;
  logic [ROW_IDX_W-1:0]              cap_row;
  logic [ROW_BITS-1:0]               diag_row;
  logic [LOG2_SRAM_BANK_DEPTH-1:0]   beat_addr;
  logic [LOG2_SRAM_BANK_DEPTH-1:0]   end_addr;

  // cmd_ready is gated by rst_n so it reads 0 while reset is held.
  assign cmd_ready  = rst_n && (state_q == ST_IDLE);
  assign accept     = cmd_valid && cmd_ready;
  assign cmd_legal  = (cmd_buf_id == BUF_ID_WIDTH'(BUF_LEFT)) ||
                      (cmd_buf_id == BUF_ID_WIDTH'(BUF_TOP));
  // Zero-extend first, then each address width takes its low bits.
  assign loc_ext    = EXT_W'(cmd_mem_loc);
  assign fetch_last = (cnt_q == CNT_W'(DIM));
  assign emit_last  = (cnt_q == CNT_W'(2 * DIM - 2));
  assign sel_left   = (buf_q == BUF_ID_WIDTH'(BUF_LEFT));
  assign sel_top    = (buf_q == BUF_ID_WIDTH'(BUF_TOP));
  // FETCH count c (c >= 1) sees the data requested at count c-1.
  assign cap_row    = ROW_IDX_W'(cnt_q - CNT_W'(1));
  assign beat_addr  = sram_base_q + LOG2_SRAM_BANK_DEPTH'(cnt_q);
  assign end_addr   = sram_base_q + LOG2_SRAM_BANK_DEPTH'(2 * DIM - 2);

  skew_diag_mux #(
    .DIM        (DIM),
    .DATA_WIDTH (DATA_WIDTH),
    .BEAT_W     (CNT_W)
  ) u_diag (
    .tile (tile_q),
    .beat (cnt_q),
    .row  (diag_row)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and all decoded outputs.
  always_comb begin
    state_d        = state_q;
    src_rd_en      = 1'b0;
    src_rd_addr    = '0;
    i_left_wr_en   = 1'b0;
    i_left_wr_addr = '0;
    i_left_wr_data = '0;
    i_top_wr_en    = 1'b0;
    i_top_wr_addr  = '0;
    i_top_wr_data  = '0;
    done           = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept && cmd_legal) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // Counts 0..DIM-1 issue reads; count DIM only captures the last row.
        if (!fetch_last) begin
          src_rd_en   = 1'b1;
          src_rd_addr = src_base_q + LOG2_SRC_DEPTH'(cnt_q);
        end
        if (fetch_last) state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (sel_left) begin
          i_left_wr_en   = 1'b1;
          i_left_wr_addr = beat_addr;
          i_left_wr_data = diag_row;
        end
        if (sel_top) begin
          i_top_wr_en   = 1'b1;
          i_top_wr_addr = beat_addr;
          i_top_wr_data = diag_row;
        end
        if (emit_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Phase counter: restarts at every state change, advances in FETCH/EMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                           cnt_q <= '0;
    else if (state_q != state_d)                          cnt_q <= '0;
    else if (state_q == ST_FETCH || state_q == ST_EMIT)   cnt_q <= cnt_q + CNT_W'(1);
  end

  // Command fields, latched only for commands that start a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q       <= '0;
      src_base_q  <= '0;
      sram_base_q <= '0;
    end else if (accept && cmd_legal) begin
      buf_q       <= cmd_buf_id;
      src_base_q  <= loc_ext[LOG2_SRC_DEPTH-1:0];
      sram_base_q <= loc_ext[LOG2_SRAM_BANK_DEPTH-1:0];
    end
  end

  // Tile register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_q <= '0;
    end else if (state_q == ST_FETCH && cnt_q != '0) begin
      tile_q[cap_row] <= src_rd_data;
    end
  end

  // Illegal buf_id: pulse err the cycle after acceptance, never leave IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= accept && !cmd_legal;
  end
  assign err = err_q;

  // Published read window; loads on the edge into DONE so it is visible
  // together with done, and holds until the same bank is loaded again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_start_q <= '0;
      left_end_q   <= '0;
      top_start_q  <= '0;
      top_end_q    <= '0;
    end else if (state_q == ST_EMIT && emit_last) begin
      if (sel_left) begin
        left_start_q <= sram_base_q;
        left_end_q   <= end_addr;
      end
      if (sel_top) begin
        top_start_q <= sram_base_q;
        top_end_q   <= end_addr;
      end
    end
  end

  assign i_left_sram_rd_start_addr = left_start_q;
  assign i_left_sram_rd_end_addr   = left_end_q;
  assign i_top_sram_rd_start_addr  = top_start_q;
  assign i_top_sram_rd_end_addr    = top_end_q;

endmodule

// File: tb/tb_skew_loader.sv
module tb_skew_loader;

  localparam int DIM = 8;
  localparam int DW  = 8;
  localparam int AW  = 10;
  localparam int RW  = DIM * DW;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_buf_id;
  logic [AW-1:0] cmd_mem_loc;
  logic          src_rd_en;
  logic [AW-1:0] src_rd_addr;
  logic [RW-1:0] src_rd_data;
  logic          i_left_wr_en;
  logic [AW-1:0] i_left_wr_addr;
  logic [RW-1:0] i_left_wr_data;
  logic          i_top_wr_en;
  logic [AW-1:0] i_top_wr_addr;
  logic [RW-1:0] i_top_wr_data;
  logic [AW-1:0] i_left_sram_rd_start_addr;
  logic [AW-1:0] i_left_sram_rd_end_addr;
  logic [AW-1:0] i_top_sram_rd_start_addr;
  logic [AW-1:0] i_top_sram_rd_end_addr;
  logic          done;
  logic          err;

  int checks = 0;
  int passed = 0;

  // Expected published windows, tracked across loads.
  logic [AW-1:0] exp_ls = '0, exp_le = '0, exp_ts = '0, exp_te = '0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] seen[2*DIM-1];

  skew_loader dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .cmd_valid                 (cmd_valid),
    .cmd_ready                 (cmd_ready),
    .cmd_buf_id                (cmd_buf_id),
    .cmd_mem_loc               (cmd_mem_loc),
    .src_rd_en                 (src_rd_en),
    .src_rd_addr               (src_rd_addr),
    .src_rd_data               (src_rd_data),
    .i_left_wr_en              (i_left_wr_en),
    .i_left_wr_addr            (i_left_wr_addr),
    .i_left_wr_data            (i_left_wr_data),
    .i_top_wr_en               (i_top_wr_en),
    .i_top_wr_addr             (i_top_wr_addr),
    .i_top_wr_data             (i_top_wr_data),
    .i_left_sram_rd_start_addr (i_left_sram_rd_start_addr),
    .i_left_sram_rd_end_addr   (i_left_sram_rd_end_addr),
    .i_top_sram_rd_start_addr  (i_top_sram_rd_start_addr),
    .i_top_sram_rd_end_addr    (i_top_sram_rd_end_addr),
    .done                      (done),
    .err                       (err)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // Scratch memory model: row at address a, lane j = (8*a + j) mod 256.
  function automatic logic [RW-1:0] src_row(input logic [AW-1:0] a);
    logic [RW-1:0] r;
    r = '0;
    for (int j = 0; j < DIM; j++) r[j*DW +: DW] = 8'((8 * int'(a) + j) & 255);
    return r;
  endfunction

  // One-cycle read latency; a filler pattern outside read responses.
  always @(posedge clk) src_rd_data <= src_rd_en ? src_row(src_rd_addr) : {DIM{8'hEE}};

  // Expected skewed beat k for a tile fetched from base.
  function automatic logic [RW-1:0] exp_beat(input logic [AW-1:0] base, input int k);
    logic [RW-1:0] b;
    logic [RW-1:0] row;
    int r;
    b = '0;
    for (int j = 0; j < DIM; j++) begin
      r = k - j;
      if (r >= 0 && r < DIM) begin
        row = src_row(AW'(int'(base) + r));
        b[j*DW +: DW] = row[j*DW +: DW];
      end
    end
    return b;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
  endtask

  // Drives one LD and checks every cycle from T1 through done (T25).
  task automatic do_load(input logic [1:0] bid, input logic [AW-1:0] loc,
                         input bit hold_next, input logic [1:0] nbid,
                         input logic [AW-1:0] nloc, output int waited);
    logic [AW-1:0] new_e, e_ls, e_le, e_ts, e_te, e_addr, e_rd;
    logic [RW-1:0] e_data, sel_data, oth_data;
    logic          sel_en, oth_en;
    logic [AW-1:0] sel_addr, oth_addr;
    bit            rd, emit;
    int            k;
    new_e       = loc + AW'(2 * DIM - 2);
    cmd_valid   = 1'b1;
    cmd_buf_id  = bid;
    cmd_mem_loc = loc;
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 40) begin @(negedge clk); waited++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      $display("FAIL load_accept: got cmd_ready=%b, expected 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end else passed++;
    exp_q.delete();
    for (int b = 0; b < 2 * DIM - 1; b++) exp_q.push_back(exp_beat(loc, b));
    for (int t = 1; t <= 3 * DIM + 1; t++) begin
      @(negedge clk);
      if (t == 1) begin
        if (hold_next) begin cmd_buf_id = nbid; cmd_mem_loc = nloc; end
        else begin cmd_valid = 1'b0; cmd_buf_id = '0; cmd_mem_loc = '0; end
      end
      rd   = (t <= DIM);
      emit = (t >= DIM + 2 && t <= 3 * DIM);
      k    = t - (DIM + 2);
      e_rd   = rd ? loc + AW'(t - 1) : '0;
      e_addr = emit ? loc + AW'(k) : '0;
      e_data = '0;
      if (emit) e_data = exp_q.pop_front();
      if (bid == 2'd0) begin
        sel_en = i_left_wr_en; sel_addr = i_left_wr_addr; sel_data = i_left_wr_data;
        oth_en = i_top_wr_en;  oth_addr = i_top_wr_addr;  oth_data = i_top_wr_data;
      end else begin
        sel_en = i_top_wr_en;  sel_addr = i_top_wr_addr;  sel_data = i_top_wr_data;
        oth_en = i_left_wr_en; oth_addr = i_left_wr_addr; oth_data = i_left_wr_data;
      end
      if (emit) seen[k] = sel_data;
      e_ls = exp_ls; e_le = exp_le; e_ts = exp_ts; e_te = exp_te;
      if (t == 3 * DIM + 1) begin
        if (bid == 2'd0) begin e_ls = loc; e_le = new_e; end
        else begin e_ts = loc; e_te = new_e; end
      end
      checks++; if (cmd_ready !== 1'b0) $display("FAIL busy_ready t=%0d: got %b, expected 0", t, cmd_ready); else passed++;
      checks++; if (src_rd_en !== rd) $display("FAIL rd_en t=%0d: got %b, expected %b", t, src_rd_en, rd); else passed++;
      checks++; if (src_rd_addr !== e_rd) $display("FAIL rd_addr t=%0d: got %0d, expected %0d", t, src_rd_addr, e_rd); else passed++;
      checks++; if (sel_en !== emit) $display("FAIL wr_en t=%0d: got %b, expected %b", t, sel_en, emit); else passed++;
      checks++; if (sel_addr !== e_addr) $display("FAIL wr_addr t=%0d: got %0d, expected %0d", t, sel_addr, e_addr); else passed++;
      checks++; if (sel_data !== e_data) $display("FAIL wr_data t=%0d: got %h, expected %h", t, sel_data, e_data); else passed++;
      checks++; if ({oth_en, oth_addr, oth_data} !== '0) $display("FAIL other_bank t=%0d: got en=%b addr=%0d data=%h, expected 0", t, oth_en, oth_addr, oth_data); else passed++;
      checks++; if (done !== (t == 3 * DIM + 1)) $display("FAIL done t=%0d: got %b, expected %b", t, done, (t == 3 * DIM + 1)); else passed++;
      checks++; if (err !== 1'b0) $display("FAIL err_quiet t=%0d: got %b, expected 0", t, err); else passed++;
      checks++;
      if ({i_left_sram_rd_start_addr, i_left_sram_rd_end_addr, i_top_sram_rd_start_addr, i_top_sram_rd_end_addr} !== {e_ls, e_le, e_ts, e_te})
        $display("FAIL published t=%0d: got %0d/%0d %0d/%0d, expected %0d/%0d %0d/%0d", t,
                 i_left_sram_rd_start_addr, i_left_sram_rd_end_addr, i_top_sram_rd_start_addr, i_top_sram_rd_end_addr,
                 e_ls, e_le, e_ts, e_te);
      else passed++;
    end
    if (bid == 2'd0) begin exp_ls = loc; exp_le = new_e; end
    else begin exp_ts = loc; exp_te = new_e; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_buf_id = '0; cmd_mem_loc = '0;
    repeat (3) @(negedge clk);
    checks++; if (cmd_ready !== 1'b0) $display("FAIL reset_ready_held: got %b, expected 0", cmd_ready); else passed++;
    checks++;
    if ({src_rd_en, src_rd_addr, i_left_wr_en, i_left_wr_addr, i_left_wr_data, i_top_wr_en, i_top_wr_addr, i_top_wr_data, done, err} !== '0)
      $display("FAIL reset_outputs: got nonzero, expected 0");
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready_release: got %b, expected 1", cmd_ready); else passed++;
    checks++;
    if ({i_left_sram_rd_start_addr, i_left_sram_rd_end_addr, i_top_sram_rd_start_addr, i_top_sram_rd_end_addr} !== '0)
      $display("FAIL reset_published: got nonzero, expected 0");
    else passed++;
  endtask

  task automatic test_left_load();
    int w;
    do_load(2'd0, 10'd0, 1'b0, 2'd0, 10'd0, w);
    checks++; if (seen[0] !== 64'h0) $display("FAIL left_beat0: got %h, expected %h", seen[0], 64'h0); else passed++;
    checks++; if (seen[7] !== 64'h070E151C232A3138) $display("FAIL left_beat7: got %h, expected %h", seen[7], 64'h070E151C232A3138); else passed++;
    checks++; if (seen[14] !== 64'h3F00000000000000) $display("FAIL left_beat14: got %h, expected %h", seen[14], 64'h3F00000000000000); else passed++;
  endtask

  task automatic test_top_load();
    int w;
    do_load(2'd1, 10'd100, 1'b0, 2'd0, 10'd0, w);
    checks++; if (i_top_sram_rd_end_addr !== 10'd114) $display("FAIL top_end: got %0d, expected 114", i_top_sram_rd_end_addr); else passed++;
    checks++; if (i_left_sram_rd_end_addr !== 10'd14) $display("FAIL left_end_kept: got %0d, expected 14", i_left_sram_rd_end_addr); else passed++;
  endtask

  task automatic test_illegal();
    @(negedge clk);
    wait_ready();
    cmd_valid = 1'b1; cmd_buf_id = 2'd3; cmd_mem_loc = 10'd5;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_buf_id = '0; cmd_mem_loc = '0;
    checks++; if (err !== 1'b1) $display("FAIL illegal_err: got %b, expected 1", err); else passed++;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL illegal_ready: got %b, expected 1", cmd_ready); else passed++;
    for (int t = 2; t <= 4; t++) begin
      @(negedge clk);
      checks++; if (err !== 1'b0) $display("FAIL illegal_err_pulse t=%0d: got %b, expected 0", t, err); else passed++;
      checks++;
      if ({src_rd_en, i_left_wr_en, i_top_wr_en, done} !== 4'b0)
        $display("FAIL illegal_quiet t=%0d: got %b, expected 0000", t, {src_rd_en, i_left_wr_en, i_top_wr_en, done});
      else passed++;
    end
  endtask

  task automatic test_wrap();
    int w;
    do_load(2'd0, 10'd1020, 1'b0, 2'd0, 10'd0, w);
    checks++; if (i_left_sram_rd_end_addr !== 10'd10) $display("FAIL wrap_end: got %0d, expected 10", i_left_sram_rd_end_addr); else passed++;
    checks++; if (i_left_sram_rd_start_addr !== 10'd1020) $display("FAIL wrap_start: got %0d, expected 1020", i_left_sram_rd_start_addr); else passed++;
  endtask

  task automatic test_reset_mid_emit();
    int w;
    logic [RW-1:0] e5;
    @(negedge clk);
    wait_ready();
    cmd_valid = 1'b1; cmd_buf_id = 2'd0; cmd_mem_loc = 10'd200;
    for (int t = 1; t <= DIM + 7; t++) begin
      @(negedge clk);
      if (t == 1) begin cmd_valid = 1'b0; cmd_buf_id = '0; cmd_mem_loc = '0; end
    end
    e5 = exp_beat(10'd200, 5);
    checks++; if (i_left_wr_en !== 1'b1 || i_left_wr_addr !== 10'd205) $display("FAIL mid_beat5: got en=%b addr=%0d, expected 1/205", i_left_wr_en, i_left_wr_addr); else passed++;
    checks++; if (i_left_wr_data !== e5) $display("FAIL mid_beat5_data: got %h, expected %h", i_left_wr_data, e5); else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, src_rd_en, src_rd_addr, i_left_wr_en, i_left_wr_addr, i_left_wr_data, i_top_wr_en, i_top_wr_addr, i_top_wr_data, done, err} !== '0)
      $display("FAIL mid_reset_outputs: got nonzero, expected 0");
    else passed++;
    checks++;
    if ({i_left_sram_rd_start_addr, i_left_sram_rd_end_addr, i_top_sram_rd_start_addr, i_top_sram_rd_end_addr} !== '0)
      $display("FAIL mid_reset_published: got %0d/%0d %0d/%0d, expected 0", i_left_sram_rd_start_addr,
               i_left_sram_rd_end_addr, i_top_sram_rd_start_addr, i_top_sram_rd_end_addr);
    else passed++;
    exp_ls = '0; exp_le = '0; exp_ts = '0; exp_te = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) $display("FAIL mid_release_ready: got %b, expected 1", cmd_ready); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL mid_release_done: got %b, expected 0", done); else passed++;
    do_load(2'd1, 10'd300, 1'b0, 2'd0, 10'd0, w);
  endtask

  task automatic test_back_to_back();
    int w;
    @(negedge clk);
    do_load(2'd0, 10'd40, 1'b1, 2'd1, 10'd60, w);
    do_load(2'd1, 10'd60, 1'b0, 2'd0, 10'd0, w);
    checks++; if (w !== 1) $display("FAIL b2b_accept_gap: got %0d wait cycles, expected 1", w); else passed++;
  endtask

  initial begin
    test_reset();
    test_left_load();
    test_top_load();
    test_illegal();
    test_wrap();
    test_reset_mid_emit();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
